// File: rtl/calc_sequencer.sv
// Board calculator controller: synchronised key presses start an add/sub/mul,
// then the magnitude is converted to BCD and held for the display and LEDs.
module calc_sequencer #(
    parameter int W           = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [2*W-1:0]   SW,
    input  logic [2:0]       KEY,
    output logic [2*W-1:0]   LEDR,
    output logic             NEG,
    output logic [3:0]       BCD0,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD3,
    output logic [1:0]       OP,
    output logic             BUSY,
    output logic             DONE
);

    localparam int RW = 2 * W;
    localparam int CW = $clog2(RW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_key_prev;
    logic [1:0]                  r_state;
    logic [W-1:0]                r_a;
    logic [W-1:0]                r_b;
    logic [1:0]                  r_op;
    logic [RW-1:0]               r_mag;
    logic                        r_neg;
    logic [RW-1:0]               r_mcand;
    logic                        r_mul_fin;
    logic [CW-1:0]               r_cnt;
    logic [RW-1:0]               r_bin;
    logic [15:0]                 r_bcd;

    logic [2:0]                  w_key;
    logic [2:0]                  w_press;
    logic                        w_any_press;
    logic [1:0]                  w_op_sel;
    logic [RW-1:0]               w_exec_mag;
    logic                        w_exec_neg;
    logic                        w_go_conv;
    logic [15:0]                 w_bcd_adj;
    logic [15:0]                 w_bcd_next;
    logic [RW-1:0]               w_bin_next;

    function automatic logic [3:0] dabble(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

    // Key synchronisers and press-edge history; released keys read as 1.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync     <= {SYNC_STAGES{3'b111}};
            r_key_prev <= 3'b111;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], KEY};
            r_key_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Press detection and fixed priority add > sub > mul.
    always_comb begin
        w_key       = r_sync[SYNC_STAGES-1];
        w_press     = r_key_prev & ~w_key;
        w_any_press = |w_press;
        if (w_press[0]) begin
            w_op_sel = OP_ADD;
        end else if (w_press[1]) begin
            w_op_sel = OP_SUB;
        end else begin
            w_op_sel = OP_MUL;
        end
    end

    // One EXEC step: full add/sub result, or one shift-add partial product.
    always_comb begin
        w_exec_mag = r_mag;
        w_exec_neg = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_exec_mag = {{W{1'b0}}, r_a} + {{W{1'b0}}, r_b};
            end
            OP_SUB: begin
                if (r_a >= r_b) begin
                    w_exec_mag = {{W{1'b0}}, r_a - r_b};
                end else begin
                    w_exec_mag = {{W{1'b0}}, r_b - r_a};
                    w_exec_neg = 1'b1;
                end
            end
            OP_MUL: begin
                if (r_b[0]) begin
                    w_exec_mag = r_mag + r_mcand;
                end else begin
                    w_exec_mag = r_mag;
                end
            end
            default: begin
                w_exec_mag = r_mag;
            end
        endcase
        w_go_conv = (r_op != OP_MUL) || r_mul_fin;
    end

    // Double-dabble step: correct every nibble, then shift the binary MSB in.
    always_comb begin
        w_bcd_adj  = {dabble(r_bcd[15:12]), dabble(r_bcd[11:8]),
                      dabble(r_bcd[7:4]), dabble(r_bcd[3:0])};
        w_bcd_next = {w_bcd_adj[14:0], r_bin[RW-1]};
        w_bin_next = {r_bin[RW-2:0], 1'b0};
    end

    // Sequencer FSM, datapath registers and held outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_ADD;
            r_mag     <= '0;
            r_neg     <= 1'b0;
            r_mcand   <= '0;
            r_mul_fin <= 1'b0;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= 16'd0;
            LEDR      <= '0;
            NEG       <= 1'b0;
            BCD0      <= 4'd0;
            BCD1      <= 4'd0;
            BCD2      <= 4'd0;
            BCD3      <= 4'd0;
            OP        <= OP_ADD;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_press) begin
                        r_a       <= SW[RW-1:W];
                        r_b       <= SW[W-1:0];
                        r_op      <= w_op_sel;
                        r_mag     <= '0;
                        r_mcand   <= {{W{1'b0}}, SW[RW-1:W]};
                        r_mul_fin <= 1'b0;
                        r_cnt     <= CW'(W - 1);
                        r_state   <= S_EXEC;
                        BUSY      <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_mag   <= w_exec_mag;
                    r_neg   <= w_exec_neg;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    // Multiply spends one extra settle cycle after the last partial product.
                    if (w_go_conv) begin
                        r_bin   <= w_exec_mag;
                        r_bcd   <= 16'd0;
                        r_cnt   <= CW'(RW - 1);
                        r_state <= S_CONV;
                    end else if (r_cnt == '0) begin
                        r_mul_fin <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= w_bin_next;
                    if (r_cnt == '0) begin
                        LEDR    <= r_mag;
                        NEG     <= r_neg;
                        BCD0    <= w_bcd_next[3:0];
                        BCD1    <= w_bcd_next[7:4];
                        BCD2    <= w_bcd_next[11:8];
                        BCD3    <= w_bcd_next[15:12];
                        OP      <= r_op;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
